// File: rtl/vreg_wb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vreg_wb_ctrl_pkg
// Shared vector-unit definitions used by the vector register write controller:
// the write-back request record (cntrl_req_t), its access/stride enums, sizing
// constants and small helpers for bank selection and the legality check.
// -----------------------------------------------------------------------------
package vreg_wb_ctrl_pkg;

    localparam int NUM_OF_WB         = 3;
    localparam int NUM_OF_VECTOR_REG = 8;
    localparam int NUM_OF_BANKS      = 2;   // power of two
    localparam int VECTOR_LENGTH     = 64;
    localparam int VECTOR_REG_WIDTH  = 64;

    // One bit wider than an element index so that out-of-range element
    // addresses can be expressed (and rejected) rather than silently wrapping.
    localparam int ADDR_FIELD_WIDTH  = $clog2(VECTOR_LENGTH) + 1;
    // Likewise one bit wider than a register index.
    localparam int VEC_PTR_WIDTH     = $clog2(NUM_OF_VECTOR_REG) + 1;
    localparam int ACCESS_LEN_WIDTH  = 4;

    localparam int REG_IDX_WIDTH     = $clog2(NUM_OF_VECTOR_REG);
    localparam int ELEM_IDX_WIDTH    = $clog2(VECTOR_LENGTH);

    typedef enum logic {
        WRITE_REQ = 1'b0,
        READ_REQ  = 1'b1
    } access_type_e;

    typedef enum logic [1:0] {
        STRIDE_UNIT    = 2'd0,
        STRIDE_CONST   = 2'd1,
        STRIDE_INDEXED = 2'd2
    } stride_e;

    typedef struct packed {
        logic                          vld;
        access_type_e                  access_type;
        stride_e                       stride_type;
        logic [ACCESS_LEN_WIDTH-1:0]   access_length;
        logic [VEC_PTR_WIDTH-1:0]      vec_reg_ptr;
        logic [ADDR_FIELD_WIDTH-1:0]   addr;
        logic [VECTOR_REG_WIDTH-1:0]   data;
    } cntrl_req_t;

    // Bank owning a register: the low bits of the register pointer.
    function automatic int bank_of(input cntrl_req_t r);
        return int'(r.vec_reg_ptr) % NUM_OF_BANKS;
    endfunction

    // A request may touch memory only if it is a single-element write that
    // lands inside the register file. stride_type is deliberately ignored.
    function automatic logic is_legal(input cntrl_req_t r);
        return (r.access_type == WRITE_REQ)
            && (r.access_length == ACCESS_LEN_WIDTH'(1))
            && (r.addr < ADDR_FIELD_WIDTH'(VECTOR_LENGTH))
            && (r.vec_reg_ptr < VEC_PTR_WIDTH'(NUM_OF_VECTOR_REG));
    endfunction

endpackage

// File: rtl/vreg_wb_ctrl_arbiter_rr_comb.sv
// -----------------------------------------------------------------------------
// arbiter_rr_comb
// Round-robin arbiter with a combinational grant. The priority pointer names the
// highest-priority requester; after a grant to k it moves to k+1 (mod N). The
// pointer only moves on a grant and returns to 0 on reset.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset
//   req    in   [N]  request vector
//   gnt    out  [N]  one-hot (or zero) grant, combinational from req and pointer
// -----------------------------------------------------------------------------
module arbiter_rr_comb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;
    int            idx;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        ptr_nxt = ptr;
        idx     = 0;
        // Scan starting at the pointer and wrapping; first requester wins.
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/vreg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// vreg_wb_ctrl
// Write-side controller of the vector register file. Arbitrates up to
// NUM_OF_WB write-back requests onto NUM_OF_BANKS single-write-port banks (one
// round-robin arbiter per bank), commits legal single-element writes, returns a
// registered acknowledge/error per port and offers a registered debug read.
// Sizing comes from vreg_wb_ctrl_pkg.
//
// Ports:
//   clk               in   clock
//   reset             in   synchronous, active-high reset
//   wb_reg_req        in   [NUM_OF_WB] write requests, held until granted
//   wb_reg_req_grant  out  [NUM_OF_WB] combinational grant (commit this edge)
//   wb_reg_rsp_vld    out  [NUM_OF_WB] one-cycle acknowledge after a grant
//   wb_reg_rsp_data   out  [NUM_OF_WB] data written, 0 on error
//   wb_err            out  [NUM_OF_WB] acknowledge of an illegal request
//   dbg_rd_en         in   debug read strobe
//   dbg_rd_reg        in   debug register index
//   dbg_rd_addr       in   debug element index
//   dbg_rd_data       out  debug data, one cycle after dbg_rd_en
// -----------------------------------------------------------------------------
module vreg_wb_ctrl
    import vreg_wb_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  cntrl_req_t                    wb_reg_req       [NUM_OF_WB],
    output logic [NUM_OF_WB-1:0]          wb_reg_req_grant,
    output logic [NUM_OF_WB-1:0]          wb_reg_rsp_vld,
    output logic [VECTOR_REG_WIDTH-1:0]   wb_reg_rsp_data  [NUM_OF_WB],
    output logic [NUM_OF_WB-1:0]          wb_err,
    input  logic                          dbg_rd_en,
    input  logic [REG_IDX_WIDTH-1:0]      dbg_rd_reg,
    input  logic [ADDR_FIELD_WIDTH-1:0]   dbg_rd_addr,
    output logic [VECTOR_REG_WIDTH-1:0]   dbg_rd_data
);

    logic [NUM_OF_WB-1:0]        bank_req [NUM_OF_BANKS];
    logic [NUM_OF_WB-1:0]        bank_gnt [NUM_OF_BANKS];
    logic [NUM_OF_WB-1:0]        legal;
    logic [VECTOR_REG_WIDTH-1:0] mem [NUM_OF_VECTOR_REG][VECTOR_LENGTH];

    // Bank decode and legality. Requests are masked during reset so nothing is
    // granted, committed or acknowledged in the reset cycle.
    always_comb begin
        for (int b = 0; b < NUM_OF_BANKS; b++) begin
            for (int i = 0; i < NUM_OF_WB; i++) begin
                bank_req[b][i] = !reset && wb_reg_req[i].vld
                                 && (bank_of(wb_reg_req[i]) == b);
            end
        end
        for (int i = 0; i < NUM_OF_WB; i++) begin
            legal[i] = is_legal(wb_reg_req[i]);
        end
    end

    for (genvar b = 0; b < NUM_OF_BANKS; b++) begin : g_bank
        arbiter_rr_comb #(.N(NUM_OF_WB)) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (bank_req[b]),
            .gnt   (bank_gnt[b])
        );
    end

    // A port targets exactly one bank, so OR-ing the bank grants is exact.
    always_comb begin
        wb_reg_req_grant = '0;
        for (int b = 0; b < NUM_OF_BANKS; b++) begin
            wb_reg_req_grant = wb_reg_req_grant | bank_gnt[b];
        end
    end

    // Element commit. Concurrent grants always hit different banks, hence
    // different registers, so the per-port writes never collide.
    // NOTE: the array is flop-based and cleared by reset; a RAM macro could not
    // be cleared in one cycle, which the reset behaviour depends on.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_OF_VECTOR_REG; r++) begin
                for (int e = 0; e < VECTOR_LENGTH; e++) begin
                    mem[r][e] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_OF_WB; i++) begin
                if (wb_reg_req_grant[i] && legal[i]) begin
                    mem[wb_reg_req[i].vec_reg_ptr[REG_IDX_WIDTH-1:0]]
                       [wb_reg_req[i].addr[ELEM_IDX_WIDTH-1:0]] <= wb_reg_req[i].data;
                end
            end
        end
    end

    // Write acknowledge: a one-cycle pulse following each grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_reg_rsp_vld <= '0;
            wb_err         <= '0;
            for (int i = 0; i < NUM_OF_WB; i++) begin
                wb_reg_rsp_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OF_WB; i++) begin
                wb_reg_rsp_vld[i]  <= wb_reg_req_grant[i];
                wb_err[i]          <= wb_reg_req_grant[i] && !legal[i];
                wb_reg_rsp_data[i] <= (wb_reg_req_grant[i] && legal[i])
                                      ? wb_reg_req[i].data : '0;
            end
        end
    end

    // Debug read samples the array before this edge's commits land, giving
    // read-before-write on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rd_data <= '0;
        end else if (dbg_rd_en) begin
            if (dbg_rd_addr < ADDR_FIELD_WIDTH'(VECTOR_LENGTH)) begin
                dbg_rd_data <= mem[dbg_rd_reg][dbg_rd_addr[ELEM_IDX_WIDTH-1:0]];
            end else begin
                dbg_rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vreg_wb_ctrl.sv
module tb_vreg_wb_ctrl;
    import vreg_wb_ctrl_pkg::*;

    localparam int NW = NUM_OF_WB;

    logic                        clk = 1'b0;
    logic                        reset;
    cntrl_req_t                  req [NW];
    logic [NW-1:0]               gnt, rsp_vld, err;
    logic [VECTOR_REG_WIDTH-1:0] rsp_data [NW];
    logic                        dbg_en;
    logic [REG_IDX_WIDTH-1:0]    dbg_reg;
    logic [ADDR_FIELD_WIDTH-1:0] dbg_addr;
    logic [VECTOR_REG_WIDTH-1:0] dbg_data;

    vreg_wb_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .wb_reg_req       (req),
        .wb_reg_req_grant (gnt),
        .wb_reg_rsp_vld   (rsp_vld),
        .wb_reg_rsp_data  (rsp_data),
        .wb_err           (err),
        .dbg_rd_en        (dbg_en),
        .dbg_rd_reg       (dbg_reg),
        .dbg_rd_addr      (dbg_addr),
        .dbg_rd_data      (dbg_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [63:0]   m_mem [NUM_OF_VECTOR_REG][VECTOR_LENGTH];
    int            m_ptr [NUM_OF_BANKS];
    logic [63:0]   m_dbg;
    logic [NW-1:0] exp_gnt, dut_gnt_s;
    int            wait_cnt [NW];

    function automatic bit m_legal(input cntrl_req_t r);
        return r.access_type == WRITE_REQ && int'(r.access_length) == 1
            && int'(r.addr) < VECTOR_LENGTH && int'(r.vec_reg_ptr) < NUM_OF_VECTOR_REG;
    endfunction

    // Per bank, the winner is the eligible port at the smallest rotational
    // distance from that bank's favoured port.
    function automatic logic [NW-1:0] model_grant();
        logic [NW-1:0] g = '0;
        if (reset) return g;
        for (int b = 0; b < NUM_OF_BANKS; b++) begin
            int best = -1;
            int bd   = NW;
            for (int i = 0; i < NW; i++) begin
                if (req[i].vld && (int'(req[i].vec_reg_ptr) % NUM_OF_BANKS) == b) begin
                    int d = (i - m_ptr[b] + NW) % NW;
                    if (d < bd) begin bd = d; best = i; end
                end
            end
            if (best >= 0) g[best] = 1'b1;
        end
        return g;
    endfunction

    // One clock: check grant mid-cycle, advance the model, check registered
    // outputs just after the edge, then retire granted requests.
    task automatic tick();
        logic [NW-1:0] ev, ee;
        logic [63:0]   ed [NW];
        @(negedge clk);
        exp_gnt   = model_grant();
        dut_gnt_s = gnt;
        check("grant", gnt, exp_gnt);
        for (int i = 0; i < NW; i++) begin
            if (reset || !req[i].vld || gnt[i]) wait_cnt[i] = 0;
            else begin
                wait_cnt[i]++;
                check($sformatf("starve%0d", i), 64'(wait_cnt[i] < NW), 64'd1);
            end
        end
        ev = '0; ee = '0;
        for (int i = 0; i < NW; i++) ed[i] = '0;
        if (reset) begin
            for (int r = 0; r < NUM_OF_VECTOR_REG; r++)
                for (int e = 0; e < VECTOR_LENGTH; e++) m_mem[r][e] = '0;
            for (int b = 0; b < NUM_OF_BANKS; b++) m_ptr[b] = 0;
            m_dbg = '0;
        end else begin
            if (dbg_en)
                m_dbg = (int'(dbg_addr) < VECTOR_LENGTH) ? m_mem[int'(dbg_reg)][int'(dbg_addr)] : '0;
            for (int i = 0; i < NW; i++) begin
                if (exp_gnt[i]) begin
                    ev[i] = 1'b1;
                    if (m_legal(req[i])) begin
                        ed[i] = req[i].data;
                        m_mem[int'(req[i].vec_reg_ptr)][int'(req[i].addr)] = req[i].data;
                    end else ee[i] = 1'b1;
                    m_ptr[int'(req[i].vec_reg_ptr) % NUM_OF_BANKS] = (i + 1) % NW;
                end
            end
        end
        @(posedge clk); #1;
        check("rsp_vld", rsp_vld, ev);
        check("wb_err", err, ee);
        for (int i = 0; i < NW; i++) check($sformatf("rsp_data%0d", i), rsp_data[i], ed[i]);
        check("dbg_rd_data", dbg_data, m_dbg);
        for (int i = 0; i < NW; i++) if (exp_gnt[i]) req[i].vld = 1'b0;
    endtask

    function automatic cntrl_req_t mk(input access_type_e t, input int len, input int r,
                                      input int a, input logic [63:0] d);
        cntrl_req_t q;
        q.vld = 1'b1; q.access_type = t; q.stride_type = STRIDE_UNIT;
        q.access_length = ACCESS_LEN_WIDTH'(len);
        q.vec_reg_ptr = VEC_PTR_WIDTH'(r); q.addr = ADDR_FIELD_WIDTH'(a); q.data = d;
        return q;
    endfunction

    function automatic cntrl_req_t rand_req();
        cntrl_req_t q;
        q.vld = 1'b1;
        q.access_type = ($urandom_range(0, 9) == 0) ? READ_REQ : WRITE_REQ;
        q.stride_type = stride_e'($urandom_range(0, 2));
        q.access_length = ($urandom_range(0, 9) == 0) ? ACCESS_LEN_WIDTH'(2) : ACCESS_LEN_WIDTH'(1);
        q.vec_reg_ptr = ($urandom_range(0, 15) == 0) ? VEC_PTR_WIDTH'($urandom_range(8, 15))
                                                     : VEC_PTR_WIDTH'($urandom_range(0, 7));
        q.addr = ($urandom_range(0, 15) == 0) ? ADDR_FIELD_WIDTH'($urandom_range(64, 127))
                                              : ADDR_FIELD_WIDTH'($urandom_range(0, 7));
        q.data = {$urandom, $urandom};
        return q;
    endfunction

    typedef struct {
        int           port;
        access_type_e t;
        int           len, r, a;
        logic [63:0]  d;
        logic         exp_err;
        logic [63:0]  exp_rsp;
        int           dr, da;
        logic [63:0]  exp_dbg;
    } vec_t;

    vec_t tbl [9];
    int   nz;

    initial begin
        tbl[0] = '{0, WRITE_REQ, 1, 3, 5,  64'hDEAD_BEEF, 1'b0, 64'hDEAD_BEEF, 3, 5,   64'hDEAD_BEEF};
        tbl[1] = '{1, WRITE_REQ, 1, 1, 7,  64'h11,        1'b0, 64'h11,        1, 7,   64'h11};
        tbl[2] = '{2, WRITE_REQ, 1, 7, 63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 7, 63, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[3] = '{0, WRITE_REQ, 1, 3, 64, 64'h1111,      1'b1, 64'h0,         3, 5,   64'hDEAD_BEEF};
        tbl[4] = '{1, READ_REQ,  1, 3, 5,  64'h1234,      1'b1, 64'h0,         3, 5,   64'hDEAD_BEEF};
        tbl[5] = '{2, WRITE_REQ, 2, 3, 5,  64'h5678,      1'b1, 64'h0,         3, 5,   64'hDEAD_BEEF};
        tbl[6] = '{0, WRITE_REQ, 1, 9, 0,  64'h9999,      1'b1, 64'h0,         1, 0,   64'h0};
        tbl[7] = '{1, WRITE_REQ, 1, 0, 0,  64'hABC,       1'b0, 64'hABC,       0, 0,   64'hABC};
        tbl[8] = '{2, WRITE_REQ, 1, 0, 1,  64'h5,         1'b0, 64'h5,         0, 100, 64'h0};

        reset = 1'b1; dbg_en = 1'b0; dbg_reg = '0; dbg_addr = '0;
        for (int i = 0; i < NW; i++) begin req[i] = '0; wait_cnt[i] = 0; end
        #1;
        tick(); tick();
        reset = 1'b0;

        // Table: single-port writes, illegal forms and boundaries.
        foreach (tbl[k]) begin
            req[tbl[k].port] = mk(tbl[k].t, tbl[k].len, tbl[k].r, tbl[k].a, tbl[k].d);
            tick();
            check($sformatf("tbl%0d_gnt", k), dut_gnt_s, 64'(1) << tbl[k].port);
            check($sformatf("tbl%0d_err", k), err[tbl[k].port], tbl[k].exp_err);
            check($sformatf("tbl%0d_vld", k), rsp_vld[tbl[k].port], 1'b1);
            check($sformatf("tbl%0d_rsp", k), rsp_data[tbl[k].port], tbl[k].exp_rsp);
            dbg_en = 1'b1; dbg_reg = REG_IDX_WIDTH'(tbl[k].dr); dbg_addr = ADDR_FIELD_WIDTH'(tbl[k].da);
            tick();
            check($sformatf("tbl%0d_dbg", k), dbg_data, tbl[k].exp_dbg);
            dbg_en = 1'b0;
        end

        // Two banks in the same cycle.
        req[0] = mk(WRITE_REQ, 1, 2, 0, 64'h22);
        req[1] = mk(WRITE_REQ, 1, 3, 1, 64'h33);
        tick();
        check("par_gnt", dut_gnt_s, 3'b011);
        check("par_vld", rsp_vld, 3'b011);

        // Read-before-write on (1,7), which holds 0x11.
        req[0] = mk(WRITE_REQ, 1, 1, 7, 64'h55);
        dbg_en = 1'b1; dbg_reg = 3'd1; dbg_addr = 7'd7;
        tick();
        check("rbw_old", dbg_data, 64'h11);
        tick();
        check("rbw_new", dbg_data, 64'h55);
        dbg_en = 1'b0;

        reset = 1'b1; tick(); reset = 1'b0;

        // Same-bank conflict, two rounds; reset lands on port 2's turn.
        for (int i = 0; i < NW; i++) req[i] = mk(WRITE_REQ, 1, 0, 0, 64'(i + 1));
        for (int i = 0; i < NW; i++) begin
            tick();
            check($sformatf("rr1_gnt%0d", i), dut_gnt_s, 64'(1) << i);
        end
        for (int i = 0; i < NW; i++) req[i] = mk(WRITE_REQ, 1, 0, 0, 64'(i + 4));
        dbg_en = 1'b1; dbg_reg = '0; dbg_addr = '0;
        tick();
        check("rr2_gnt0", dut_gnt_s, 3'b001);
        check("rr1_final", dbg_data, 64'h3);
        dbg_en = 1'b0;
        tick();
        check("rr2_gnt1", dut_gnt_s, 3'b010);
        reset = 1'b1;
        tick();
        check("rst_gnt", dut_gnt_s, 3'b000);
        check("rst_vld", rsp_vld, 3'b000);
        check("rst_err", err, 3'b000);
        check("rst_data2", rsp_data[2], 64'h0);
        check("rst_dbg", dbg_data, 64'h0);
        reset = 1'b0;
        for (int i = 0; i < NW; i++) req[i].vld = 1'b0;

        nz = 0;
        dbg_en = 1'b1;
        for (int r = 0; r < NUM_OF_VECTOR_REG; r++) begin
            for (int e = 0; e < VECTOR_LENGTH; e++) begin
                dbg_reg = REG_IDX_WIDTH'(r); dbg_addr = ADDR_FIELD_WIDTH'(e);
                tick();
                if (dbg_data !== 64'h0) nz++;
            end
        end
        check("mem_cleared", 64'(nz), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < NW; i++)
                if (!req[i].vld && $urandom_range(0, 1) == 1) req[i] = rand_req();
            dbg_en = ($urandom_range(0, 1) == 1);
            dbg_reg = REG_IDX_WIDTH'($urandom_range(0, 7));
            dbg_addr = ($urandom_range(0, 15) == 0) ? ADDR_FIELD_WIDTH'($urandom_range(64, 127))
                                                    : ADDR_FIELD_WIDTH'($urandom_range(0, 7));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vreg_wb_ctrl.md
# vreg_wb_ctrl

Write-side controller of the vector register file, directly downstream of the write-back stage. It accepts up to NUM_OF_WB concurrent `cntrl_req_t` write requests. It arbitrates them onto NUM_OF_BANKS single-write-port register banks, commits element writes, and returns a per-port grant plus a one-cycle-later write acknowledge. It also provides a registered debug read port for checking register contents.

## Interface

Parameters:
- NUM_OF_WB, 3: number of write-back request ports.
- NUM_OF_VECTOR_REG, 8: number of vector registers.
- NUM_OF_BANKS, 2: number of write banks; bank = vec_reg_ptr % NUM_OF_BANKS. Must be a power of two.
- VECTOR_LENGTH, 64: elements per vector register.
- VECTOR_REG_WIDTH, 64: element width, which is also the `cntrl_req_t.data` width.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- wb_reg_req  in  cntrl_req_t [NUM_OF_WB]  write requests; each is held stable until granted.
- wb_reg_req_grant  out  1 [NUM_OF_WB]  combinational; request i is committed at this clock edge.
- wb_reg_rsp_vld  out  1 [NUM_OF_WB]  registered write acknowledge.
- wb_reg_rsp_data  out  VECTOR_REG_WIDTH [NUM_OF_WB]  data actually written; 0 on error.
- wb_err  out  1 [NUM_OF_WB]  registered; high together with rsp_vld on an illegal request.
- dbg_rd_en  in  1  debug read strobe.
- dbg_rd_reg  in  $clog2(NUM_OF_VECTOR_REG)  debug register index.
- dbg_rd_addr  in  ADDR_FIELD_WIDTH  debug element index.
- dbg_rd_data  out  VECTOR_REG_WIDTH  debug read data, valid one cycle after dbg_rd_en.

## Operation

- Request i is eligible when `wb_reg_req[i].vld`. Its bank is vec_reg_ptr[$clog2(NUM_OF_BANKS)-1:0].
- Each bank has one round-robin arbiter over the eligible ports targeting that bank.
  - Pointer reset value: port 0 has highest priority.
  - After a grant to port k, port k+1 (mod NUM_OF_WB) becomes highest priority for that bank.
  - The pointer advances only on a grant.
- Different banks grant independently, so up to min(NUM_OF_WB, NUM_OF_BANKS) grants per cycle.
- Commit: on a clock edge with grant[i]=1, mem[vec_reg_ptr][addr] <= data, provided the request is legal.
- Legal request: access_type == WRITE_REQ, access_length == 1, addr < VECTOR_LENGTH, vec_reg_ptr < NUM_OF_VECTOR_REG.
- Illegal request:
  - It is still granted, so the upstream stage never stalls forever.
  - No memory write occurs.
  - Next cycle: wb_err[i]=1, rsp_vld[i]=1, rsp_data[i]=0.
- stride_type is ignored; every request writes a single element.
- Same bank, same register and element, same cycle: requests serialize through the round-robin; the later grant's data persists.
- Debug read: dbg_rd_data is registered from mem.
  - A same-cycle debug read of an element being written returns the old value (read-before-write).
  - An out-of-range debug index returns 0.

## Timing

- Grant latency: 0 cycles. Grant is combinational from wb_reg_req and the arbiter pointers; there is no combinational path from grant back into request.
- Write is visible to the debug port on the cycle after commit. A read issued at commit+1 returns the new data at commit+2.
- rsp_vld[i] is a 1-cycle pulse exactly one cycle after grant[i]. Back-to-back grants produce back-to-back pulses.
- Reset (synchronous, also when asserted mid-operation):
  - Outputs: grant=0, rsp_vld=0, rsp_data=0, wb_err=0, dbg_rd_data=0.
  - Arbiter pointers return to 0.
  - Memory contents are cleared to 0 over a reset of one cycle (flop-based array).
  - A grant in progress in the reset cycle is discarded: no write and no response.
- Starvation bound: a held request is granted within NUM_OF_WB cycles.

## Structure

- Shared package (existing vector package):
  - `cntrl_req_t`, access_type enum (WRITE_REQ, READ_REQ), stride enum.
  - NUM_OF_WB, NUM_OF_VECTOR_REG, VECTOR_REG_WIDTH, ADDR_FIELD_WIDTH.
  - New constants NUM_OF_BANKS and VECTOR_LENGTH.
- Sub-module: reuse `arbiter_rr` with one instance per bank; its request vector is wb_reg_req[i].vld && bank match. If its grant is registered, replace it with a combinational variant `arbiter_rr_comb` having the same pointer semantics.
- The top level holds bank decode, the legality check, the memory array, the response registers and the debug read.

## Test plan

- Single write: port0 writes reg 3, addr 5, data 0xDEAD_BEEF → grant0 same cycle; next cycle rsp_vld0=1, rsp_data0=0xDEAD_BEEF, wb_err0=0; debug read of (3,5) returns 0xDEAD_BEEF.
- Bank parallelism: port0 writes reg 2 and port1 writes reg 3 (different banks) in the same cycle → both granted that cycle; both rsp_vld pulses occur the next cycle.
- Bank conflict and fairness: all three ports write reg 0, addr 0 (data 1, 2, 3), held continuously → grant order 0, 1, 2, one grant per cycle; final mem[0][0]=3; the next conflicting round starts at port 0.
- Illegal requests: addr=VECTOR_LENGTH, or access_type=READ_REQ, or access_length=2 → granted; next cycle wb_err=1, rsp_vld=1, rsp_data=0; memory is unchanged.
- Reset mid-operation: assert reset while port2 is being granted → no response pulse; all outputs are 0 in the following cycle; debug reads of all elements return 0.
- Debug read-before-write: dbg_rd of (1,7) in the same cycle as a commit of 0x55 to (1,7) → returns the old value; a repeat read the next cycle returns 0x55.
